// File: rtl/page_walker_pkg.sv
// page_walker_pkg
//   Shared definitions for the page-table refill engine: walker state
//   encoding, PTE field positions and the default page-number width.
//   No ports.
package page_walker_pkg;

  localparam int PW_PAGE_NUM_WIDTH = 20;

  typedef enum logic [1:0] {
    PW_IDLE   = 2'd0,
    PW_FETCH  = 2'd1,
    PW_UPDATE = 2'd2,
    PW_FAULT  = 2'd3
  } pw_state_e;

  // PTE layout: ppage in the top PAGE_NUM_WIDTH bits, valid flag in bit 0
  localparam int PTE_VALID_BIT = 0;
  localparam int PTE_PPAGE_MSB = 31;

  function automatic int pte_ppage_lsb(input int page_num_width);
    return PTE_PPAGE_MSB + 1 - page_num_width;
  endfunction

endpackage

// File: rtl/page_walker_if.sv
// page_walker_if
//   PTE read port between the walker and memory.
//   mem_req   : read request, held until mem_ack
//   mem_addr  : PTE physical address, stable while mem_req is high
//   mem_ack   : read acknowledge, mem_rdata valid in the same cycle
//   mem_rdata : PTE contents
//   master = walker side, slave = memory side.
interface page_walker_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/page_walker_pte_addr.sv
// pw_pte_addr
//   Combinational PTE address generator: base + vpage * 4, 32-bit,
//   wrapping modulo 2^32 (carry discarded).
//   i_base  : page table base (physical, word aligned)
//   i_vpage : virtual page number
//   o_addr  : PTE physical address
module pw_pte_addr
  import page_walker_pkg::*;
#(
  parameter int PAGE_NUM_WIDTH = PW_PAGE_NUM_WIDTH
) (
  input  logic [31:0]               i_base,
  input  logic [PAGE_NUM_WIDTH-1:0] i_vpage,
  output logic [31:0]               o_addr
);

  logic [31:0] w_scaled;

  // Each PTE is one word; bits shifted past bit 31 are dropped on purpose.
  assign w_scaled = {{(32-PAGE_NUM_WIDTH){1'b0}}, i_vpage} << 2;
  assign o_addr   = i_base + w_scaled;

endmodule

// File: rtl/page_walker.sv
// page_walker
//   Refill engine for the single-entry translation unit. On a translation
//   error it latches the faulting address, stalls the pipeline, reads the
//   PTE over io_mem, then pulses a translation reload or a page fault.
//
//   Optional feature: define PW_TIMEOUT_EN to give up on a PTE read after
//   TIMEOUT_CYCLES cycles without an ack (bus_err pulse, back to IDLE).
//
//   Ports:
//     clk, rst_n          clock, async active-low reset
//     i_mmu_error         translation error from the translation unit
//     i_vaddr             faulting virtual address
//     i_stall             stall from the rest of the pipeline
//     i_ptbr, i_ptbr_we   page table base and its write enable
//     io_mem              PTE read port (master side)
//     o_mmu_update        one-cycle reload strobe (held while i_stall)
//     o_mmu_en            reload enable value
//     o_vpage, o_ppage    reload page numbers
//     o_stall             walk in progress
//     o_fault             one-cycle page fault pulse
//     o_bus_err           one-cycle PTE read timeout pulse
//     o_badvaddr          latched faulting address
//
//   state  | meaning
//   IDLE   | waiting for a translation error
//   FETCH  | PTE read outstanding, pipeline stalled
//   UPDATE | reload strobe to the translation unit, held while stalled
//   FAULT  | one-cycle page fault pulse
module page_walker
  import page_walker_pkg::*;
#(
  parameter int PAGE_NUM_WIDTH = PW_PAGE_NUM_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_mmu_error,
  input  logic [31:0]               i_vaddr,
  input  logic                      i_stall,
  input  logic [31:0]               i_ptbr,
  input  logic                      i_ptbr_we,
  page_walker_if.master             io_mem,
  output logic                      o_mmu_update,
  output logic                      o_mmu_en,
  output logic [PAGE_NUM_WIDTH-1:0] o_vpage,
  output logic [PAGE_NUM_WIDTH-1:0] o_ppage,
  output logic                      o_stall,
  output logic                      o_fault,
  output logic                      o_bus_err,
  output logic [31:0]               o_badvaddr
);

  localparam int OFFSET_WIDTH = 32 - PAGE_NUM_WIDTH;
  localparam int PPAGE_LSB    = pte_ppage_lsb(PAGE_NUM_WIDTH);

  localparam logic [1:0] S_IDLE   = PW_IDLE;
  localparam logic [1:0] S_FETCH  = PW_FETCH;
  localparam logic [1:0] S_UPDATE = PW_UPDATE;
  localparam logic [1:0] S_FAULT  = PW_FAULT;

  logic [1:0]                r_state;
  logic [31:0]               r_ptbr;
  logic [31:0]               r_badvaddr;
  logic [PAGE_NUM_WIDTH-1:0] r_vpage;
  logic [PAGE_NUM_WIDTH-1:0] r_ppage;
  logic [31:0]               r_mem_addr;
  logic                      r_mem_req;
  logic                      r_stall;

  logic [PAGE_NUM_WIDTH-1:0] w_vpage;
  logic [PAGE_NUM_WIDTH-1:0] w_pte_ppage;
  logic                      w_pte_valid;
  logic [31:0]               w_pte_addr;
  logic                      w_unused_pte;
  logic                      w_tmo_expire;

  assign w_vpage      = i_vaddr[31:OFFSET_WIDTH];
  assign w_pte_ppage  = io_mem.mem_rdata[PTE_PPAGE_MSB:PPAGE_LSB];
  assign w_pte_valid  = io_mem.mem_rdata[PTE_VALID_BIT];
  assign w_unused_pte = ^io_mem.mem_rdata[PPAGE_LSB-1:PTE_VALID_BIT+1];

  // Uses the base register as it stands before this cycle's write, so an
  // error coinciding with i_ptbr_we walks with the old base.
  pw_pte_addr #(
    .PAGE_NUM_WIDTH (PAGE_NUM_WIDTH)
  ) u_pte_addr (
    .i_base  (r_ptbr),
    .i_vpage (w_vpage),
    .o_addr  (w_pte_addr)
  );

`ifdef PW_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_bus_err;

  // Terminal count reached in the last allowed FETCH cycle; an ack in that
  // same cycle still wins.
  assign w_tmo_expire = (r_state == S_FETCH) && !io_mem.mem_ack && (r_tmo_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_tmo_expire;
      if (r_state == S_IDLE && i_mmu_error)
        r_tmo_cnt <= TMO_LOAD;
      else if (r_state == S_FETCH && r_tmo_cnt != '0)
        r_tmo_cnt <= r_tmo_cnt - 1'b1;
    end
  end

  assign o_bus_err = r_bus_err;
`else
  logic w_unused_tmo;

  assign w_tmo_expire = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
  assign o_bus_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptbr     <= '0;
      r_badvaddr <= '0;
      r_vpage    <= '0;
      r_ppage    <= '0;
      r_mem_addr <= '0;
      r_mem_req  <= 1'b0;
      r_stall    <= 1'b0;
    end else begin
      if (i_ptbr_we)
        r_ptbr <= i_ptbr;

      case (r_state)
        S_IDLE: begin
          if (i_mmu_error) begin
            r_badvaddr <= i_vaddr;
            r_vpage    <= w_vpage;
            r_mem_addr <= w_pte_addr;
            r_mem_req  <= 1'b1;
            r_stall    <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (io_mem.mem_ack) begin
            r_ppage   <= w_pte_ppage;
            r_mem_req <= 1'b0;
            r_stall   <= 1'b0;
            r_state   <= w_pte_valid ? S_UPDATE : S_FAULT;
          end else if (w_tmo_expire) begin
            r_mem_req <= 1'b0;
            r_stall   <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_UPDATE: begin
          // The translation unit ignores the strobe while stalled, so hold it.
          if (!i_stall)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_mem.mem_req  = r_mem_req;
  assign io_mem.mem_addr = r_mem_addr;

  assign o_mmu_update = (r_state == S_UPDATE);
  assign o_mmu_en     = (r_state == S_UPDATE);
  assign o_fault      = (r_state == S_FAULT);
  assign o_vpage      = r_vpage;
  assign o_ppage      = r_ppage;
  assign o_stall      = r_stall;
  assign o_badvaddr   = r_badvaddr;

endmodule

// File: tb/tb_page_walker.sv
// tb_page_walker
//   Directed bench for page_walker. Each walk is described by its error
//   cycle, ack cycle, PTE and stall length; an expected timeline of all
//   outputs is filled in from those, and a negedge process compares the DUT
//   against it every cycle. Literal expectations after each walk pin the
//   timeline. Timeout scenarios run when PW_TIMEOUT_EN is defined.
module tb_page_walker;

  localparam int PNW  = 20;
  localparam int OFFW = 32 - PNW;
  localparam int TMO  = 8;
  localparam int MAXC = 1024;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_mmu_error = 1'b0;
  logic [31:0]      i_vaddr = '0;
  logic             i_stall = 1'b0;
  logic [31:0]      i_ptbr = '0;
  logic             i_ptbr_we = 1'b0;
  logic             o_mmu_update, o_mmu_en, o_stall, o_fault, o_bus_err;
  logic [PNW-1:0]   o_vpage, o_ppage;
  logic [31:0]      o_badvaddr;

  page_walker_if mem_if ();

  page_walker #(
    .PAGE_NUM_WIDTH (PNW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_mmu_error  (i_mmu_error),
    .i_vaddr      (i_vaddr),
    .i_stall      (i_stall),
    .i_ptbr       (i_ptbr),
    .i_ptbr_we    (i_ptbr_we),
    .io_mem       (mem_if),
    .o_mmu_update (o_mmu_update),
    .o_mmu_en     (o_mmu_en),
    .o_vpage      (o_vpage),
    .o_ppage      (o_ppage),
    .o_stall      (o_stall),
    .o_fault      (o_fault),
    .o_bus_err    (o_bus_err),
    .o_badvaddr   (o_badvaddr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  // expected timeline, indexed by cycle
  bit           e_req   [MAXC];
  bit           e_stall [MAXC];
  bit           e_upd   [MAXC];
  bit           e_fault [MAXC];
  bit           e_berr  [MAXC];
  bit [31:0]    e_addr  [MAXC];
  bit [31:0]    e_bad   [MAXC];
  bit [PNW-1:0] e_vp    [MAXC];
  bit [PNW-1:0] e_pp    [MAXC];

  bit [31:0] m_ptbr = '0;

  // observations for the literal pins
  int          upd_cnt = 0, fault_cnt = 0, berr_cnt = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_vp = '0, last_pp = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Error in cycle n; ack in cycle a (or none -> timeout); s stall cycles
  // entering UPDATE.
  function automatic void model_walk(input int n, input int a, input bit acked,
                                     input bit [31:0] base, input bit [31:0] va,
                                     input bit [31:0] pte, input int s);
    bit [31:0] vpn;
    bit [31:0] addr;
    int        last;
    vpn  = va >> OFFW;
    addr = base + vpn * 4;
    for (int c = n + 1; c < MAXC; c++) e_bad[c] = va;
    last = acked ? a : n + TMO;
    for (int c = n + 1; c <= last && c < MAXC; c++) begin
      e_req[c]   = 1'b1;
      e_stall[c] = 1'b1;
      e_addr[c]  = addr;
    end
    if (!acked) begin
      if (last + 1 < MAXC) e_berr[last + 1] = 1'b1;
    end else if (pte[0]) begin
      for (int c = a + 1; c <= a + 1 + s && c < MAXC; c++) begin
        e_upd[c] = 1'b1;
        e_vp[c]  = PNW'(vpn);
        e_pp[c]  = PNW'(pte >> OFFW);
      end
    end else if (a + 1 < MAXC) begin
      e_fault[a + 1] = 1'b1;
    end
  endfunction

  function automatic void model_clear_from(input int c0);
    for (int c = c0; c < MAXC; c++) begin
      e_req[c] = 0; e_stall[c] = 0; e_upd[c] = 0; e_fault[c] = 0; e_berr[c] = 0;
      e_addr[c] = '0; e_bad[c] = '0; e_vp[c] = '0; e_pp[c] = '0;
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && cyc < MAXC) begin
      chk("mem_req",    mem_if.mem_req, 32'(e_req[cyc]));
      chk("stall_o",    o_stall,        32'(e_stall[cyc]));
      chk("mmu_update", o_mmu_update,   32'(e_upd[cyc]));
      chk("fault",      o_fault,        32'(e_fault[cyc]));
      chk("bus_err",    o_bus_err,      32'(e_berr[cyc]));
      chk("badvaddr",   o_badvaddr,     e_bad[cyc]);
      if (e_req[cyc]) chk("mem_addr", mem_if.mem_addr, e_addr[cyc]);
      if (e_upd[cyc]) begin
        chk("mmu_en", o_mmu_en, 32'd1);
        chk("vpage",  o_vpage,  32'(e_vp[cyc]));
        chk("ppage",  o_ppage,  32'(e_pp[cyc]));
      end
      if (o_mmu_update === 1'b1) begin
        upd_cnt++;
        last_vp = 32'(o_vpage);
        last_pp = 32'(o_ppage);
      end
      if (mem_if.mem_req === 1'b1) last_addr = mem_if.mem_addr;
      if (o_fault === 1'b1)   fault_cnt++;
      if (o_bus_err === 1'b1) berr_cnt++;
    end
  end

  // Caller is in the cycle that raises the error. mid_err / mid_base inject a
  // second error / a base write in the first FETCH cycle.
  task automatic walk(input logic [31:0] va, input int dly, input logic [31:0] pte,
                      input int s, input bit acked, input bit mid_err, input bit mid_base);
    int n;
    n = cyc;
    model_walk(n, n + dly, acked, m_ptbr, va, pte, s);
    i_mmu_error = 1'b1;
    i_vaddr     = va;
    tick;
    i_mmu_error = mid_err;
    i_vaddr     = 32'h0777_7123;
    i_ptbr_we   = mid_base;
    i_ptbr      = 32'h0020_0000;
    if (acked) begin
      for (int k = 1; k < dly; k++) begin
        tick;
        i_mmu_error = 1'b0;
        i_ptbr_we   = 1'b0;
      end
      mem_if.mem_ack   = 1'b1;
      mem_if.mem_rdata = pte;
      tick;
      mem_if.mem_ack   = 1'b0;
      mem_if.mem_rdata = '0;
      i_mmu_error      = 1'b0;
      i_ptbr_we        = 1'b0;
      i_stall          = (s > 0);
      repeat (s) tick;
      i_stall = 1'b0;
    end else begin
      for (int k = 0; k < TMO; k++) begin
        tick;
        i_mmu_error = 1'b0;
        i_ptbr_we   = 1'b0;
      end
    end
    if (mid_base) m_ptbr = 32'h0020_0000;
    repeat (2) tick;
  endtask

  task automatic set_ptbr(input logic [31:0] v);
    i_ptbr    = v;
    i_ptbr_we = 1'b1;
    tick;
    i_ptbr_we = 1'b0;
    m_ptbr    = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int u0, f0, b0, n;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req",  mem_if.mem_req, 32'd0);
    chk("rst_stall",    o_stall,        32'd0);
    chk("rst_update",   o_mmu_update,   32'd0);
    chk("rst_badvaddr", o_badvaddr,     32'd0);
    rst_n = 1'b1;
    repeat (2) tick;

    // basic valid walk, ack after 3 cycles
    set_ptbr(32'h0010_0000);
    u0 = upd_cnt;
    walk(32'h0000_3ABC, 3, 32'h0004_5001, 0, 1'b1, 1'b0, 1'b0);
    chk("t1_addr",    last_addr,     32'h0010_000C);
    chk("t1_vpage",   last_vp,       32'h0000_0003);
    chk("t1_ppage",   last_pp,       32'h0000_0045);
    chk("t1_upd_len", upd_cnt - u0,  32'd1);

    // same walk with an invalid PTE
    u0 = upd_cnt; f0 = fault_cnt;
    walk(32'h0000_3ABC, 3, 32'h0004_5000, 0, 1'b1, 1'b0, 1'b0);
    chk("t2_faults",   fault_cnt - f0, 32'd1);
    chk("t2_no_upd",   upd_cnt - u0,   32'd0);
    chk("t2_badvaddr", o_badvaddr,     32'h0000_3ABC);

    // address wrap, minimum latency (ack in the first FETCH cycle)
    set_ptbr(32'hFFFF_FFF0);
    walk(32'h0000_5000, 1, 32'h0012_3001, 0, 1'b1, 1'b0, 1'b0);
    chk("t3_wrap_addr", last_addr, 32'h0000_0004);

    // 4 stall cycles entering UPDATE
    u0 = upd_cnt;
    walk(32'h0ABC_D123, 2, 32'h0F0F_0001, 4, 1'b1, 1'b0, 1'b0);
    chk("t4_upd_len", upd_cnt - u0, 32'd5);
    chk("t4_ppage",   last_pp,      32'h0000_F0F0);

    // base write in the error cycle: this walk still uses the old base
    i_ptbr    = 32'h0030_0000;
    i_ptbr_we = 1'b1;
    walk(32'h0000_1000, 2, 32'h0000_1001, 0, 1'b1, 1'b0, 1'b0);
    m_ptbr = 32'h0030_0000;
    chk("t5_old_base", last_addr, 32'hFFFF_FFF4);
    walk(32'h0000_2000, 2, 32'h0000_2001, 0, 1'b1, 1'b0, 1'b0);
    chk("t5_new_base", last_addr, 32'h0030_0008);

    // second error and base write during FETCH
    u0 = upd_cnt;
    walk(32'h0000_7000, 4, 32'h0099_9001, 0, 1'b1, 1'b1, 1'b1);
    chk("t6_addr",     last_addr,    32'h0030_001C);
    chk("t6_one_upd",  upd_cnt - u0, 32'd1);
    chk("t6_badvaddr", o_badvaddr,   32'h0000_7000);
    walk(32'h0000_1000, 2, 32'h0000_5001, 0, 1'b1, 1'b0, 1'b0);
    chk("t6_next_base", last_addr, 32'h0020_0004);

    // fault while the pipeline is stalled is still a single pulse
    f0 = fault_cnt;
    walk(32'h0000_4000, 2, 32'h0000_0000, 3, 1'b1, 1'b0, 1'b0);
    chk("t7_fault_len", fault_cnt - f0, 32'd1);

`ifdef PW_TIMEOUT_EN
    u0 = upd_cnt; f0 = fault_cnt; b0 = berr_cnt;
    walk(32'h0000_8000, 0, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    chk("t8_berr",     berr_cnt - b0,  32'd1);
    chk("t8_no_fault", fault_cnt - f0, 32'd0);
    chk("t8_no_upd",   upd_cnt - u0,   32'd0);
    u0 = upd_cnt; b0 = berr_cnt;
    walk(32'h0000_9000, TMO, 32'h0001_2001, 0, 1'b1, 1'b0, 1'b0);
    chk("t8_ack_last_upd", upd_cnt - u0,  32'd1);
    chk("t8_ack_last_ok",  berr_cnt - b0, 32'd0);
`else
    u0 = upd_cnt;
    walk(32'h0000_9000, 40, 32'h0001_2001, 0, 1'b1, 1'b0, 1'b0);
    chk("t8_long_wait_upd", upd_cnt - u0, 32'd1);
    chk("t8_no_berr",       berr_cnt,     32'd0);
`endif

    // reset in the middle of FETCH
    n = cyc;
    model_walk(n, n + 2, 1'b1, m_ptbr, 32'h0000_6000, 32'h0, 0);
    model_clear_from(n + 3);
    i_mmu_error = 1'b1;
    i_vaddr     = 32'h0000_6000;
    tick;
    i_mmu_error = 1'b0;
    tick;
    chk("t9_req_before", mem_if.mem_req, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t9_req_async",   mem_if.mem_req, 32'd0);
    chk("t9_stall_async", o_stall,        32'd0);
    tick;
    rst_n  = 1'b1;
    m_ptbr = '0;
    tick;
    walk(32'h0000_3000, 2, 32'h0000_7001, 0, 1'b1, 1'b0, 1'b0);
    chk("t9_base_reset", last_addr, 32'h0000_000C);

    repeat (3) tick;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/page_walker.md
# page_walker

Refill engine for the single-entry address translation unit: it consumes that unit's translation-error signal and produces the `vpage`/`ppage`/enable/update strobe that reloads it. On an error it latches the faulting virtual address and stalls the pipeline. It fetches the page table entry from memory over a request/acknowledge port, then either pulses a translation update or raises a page fault toward the control unit.

## Interface
- `PAGE_NUM_WIDTH`, 20: page-number width; offset width is 32-`PAGE_NUM_WIDTH`.
- `TIMEOUT_CYCLES`, 255: cycles to wait for `mem_ack` before giving up; used only with `PW_TIMEOUT_EN`.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mmu_error_i`  in  1  translation error from the translation unit.
- `vaddr_i`  in  32  virtual address presented with the error.
- `stall_i`  in  1  stall from all other pipeline sources.
- `ptbr_i`  in  32  page table base, physical, word aligned.
- `ptbr_we_i`  in  1  load `ptbr_i` into the base register.
- `mem_req_o`  out  1  PTE read request.
- `mem_addr_o`  out  32  PTE physical address.
- `mem_ack_i`  in  1  read acknowledge; `mem_rdata_i` is valid in the same cycle.
- `mem_rdata_i`  in  32  PTE: [31:32-`PAGE_NUM_WIDTH`] ppage, [0] valid.
- `mmu_update_o`  out  1  one-cycle translation reload strobe.
- `mmu_en_o`  out  1  enable value for reload; always 1 when `mmu_update_o` is high.
- `vpage_o`, `ppage_o`  out  `PAGE_NUM_WIDTH`  reload values.
- `stall_o`  out  1  walk in progress; ORed into the pipeline stall externally.
- `fault_o`  out  1  one-cycle page-fault pulse.
- `bus_err_o`  out  1  one-cycle timeout pulse; tied 0 without `PW_TIMEOUT_EN`.
- `badvaddr_o`  out  32  latched faulting address; held until the next walk.

## Operation
- States: IDLE, FETCH, UPDATE, FAULT.
- IDLE:
  - `mmu_error_i`=1 -> latch `vaddr_i` into `badvaddr_o`.
  - Compute and register `mem_addr_o` = `ptbr` + {vpage, 2'b00}, 32-bit, wrap modulo 2^32, carry discarded.
  - Go to FETCH.
- FETCH:
  - `mem_req_o`=1; `mem_addr_o` stays stable until the ack.
  - On `mem_ack_i`: capture ppage from the PTE.
  - Valid bit=1 -> UPDATE; valid bit=0 -> FAULT.
- UPDATE:
  - `mmu_update_o`=1, `mmu_en_o`=1, `vpage_o` = latched vpage, `ppage_o` = captured ppage.
  - Held while `stall_i`=1; the translation unit ignores an update under stall.
  - Leaves for IDLE in the first cycle with `stall_i`=0.
- FAULT: `fault_o`=1 for one cycle -> IDLE. The control unit takes the exception and reads `badvaddr_o`.
- `mmu_error_i` outside IDLE is ignored.
- `ptbr_we_i` takes effect on any cycle. A walk already in FETCH keeps its registered address; the new base applies from the next walk.
- An error arriving in the same cycle as `ptbr_we_i` uses the old base.

## Timing
- Reset values: state IDLE; all outputs 0; `ptbr` 0.
- `stall_o` = 1 in FETCH only, and is registered. It is 0 in UPDATE so that the translation unit latches.
- Error cycle N -> FETCH at N+1 -> ack at cycle A (A ≥ N+1) -> UPDATE or FAULT at A+1 -> IDLE at A+2 when unstalled. Minimum error-to-update latency is 2 cycles.
- The requester holds `mem_req_o` until the ack. There is exactly one outstanding request, and a second request needs the walker back in IDLE.
- Reset mid-walk: immediate return to IDLE; `mem_req_o` and `stall_o` drop asynchronously. The memory side must discard a pending request.

## Configuration
- `PW_TIMEOUT_EN` defined:
  - FETCH counts cycles from its first cycle.
  - If `TIMEOUT_CYCLES` cycles pass with no ack, `mem_req_o` drops, `bus_err_o` pulses 1 cycle, and the state goes to IDLE. `fault_o` stays 0.
  - An ack in the last counted cycle wins over the timeout.
- Not defined: FETCH waits forever, and the counter and `bus_err_o` logic are absent.

## Structure
- Shared package holds:
  - state enum;
  - PTE field constants: valid bit index 0, ppage MSB/LSB derived from `PAGE_NUM_WIDTH`;
  - default `PAGE_NUM_WIDTH`.
- One sub-module, `pw_pte_addr`: combinational PTE address generator (base + scaled vpage) for separate unit test.

## Test plan
- ptbr=0x0010_0000, error with vaddr=0x0000_3ABC, ack after 3 cycles with rdata=0x0004_5001 -> `mem_addr_o`=0x0010_000C; 1-cycle `mmu_update_o` with vpage=0x00003, ppage=0x00045, `mmu_en_o`=1.
- Same walk, rdata=0x0004_5000 -> `fault_o` one cycle, no update, `badvaddr_o`=0x0000_3ABC.
- ptbr=0xFFFF_FFF0, vaddr=0x0000_5000 -> `mem_addr_o`=0x0000_0004 (wrap).
- `stall_i`=1 for 4 cycles entering UPDATE -> `mmu_update_o` high 5 cycles, with constant vpage/ppage.
- With `PW_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8:
  - no ack -> `bus_err_o` after cycle 8 of FETCH;
  - ack on cycle 8 -> normal update.
- Drop `rst_n` mid-FETCH -> `mem_req_o`, `stall_o` = 0 immediately. A second error while in FETCH is ignored, with exactly one update.
